addr_seq_ctrl: RTL
==================

ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 7, width of the address counter being sequenced (max 127 addresses).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, cycles from the last counter enable until its delayed address output is final.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  request a burst of len_i addresses; accepted only when ready_o=1.
REQ-007 len_i  input  CNT_WIDTH  burst length, sampled on accepted start_i.
REQ-008 stall_i  input  1  downstream backpressure; suppresses counter enables while high.
REQ-009 abort_i  input  1  terminate the current burst early.
REQ-010 en_o  output  1  increment strobe to the address counter (its en).
REQ-011 cnt_clr_o  output  1  clear strobe to the address counter (its done_i).
REQ-012 ready_o  output  1  high in IDLE only.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 done_o  output  1  one-cycle pulse at burst completion or abort.
REQ-015 issued_o  output  CNT_WIDTH  number of enables issued in the current burst.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: on start_i with len_i!=0, latch len_i, clear issued count, go to RUN next cycle.
REQ-018 IDLE: on start_i with len_i==0, go to DONE without issuing any enable.
REQ-019 RUN: en_o = !stall_i (combinational); each cycle with en_o=1 increments the issued count by 1.
REQ-020 RUN: when en_o=1 and issued count == latched len-1, go to DRAIN; exactly len enables are issued per burst.
REQ-021 RUN with stall_i held high: remain in RUN, en_o=0, count unchanged, with no timeout.
REQ-022 DRAIN: en_o=0, wait exactly DRAIN_CYCLES cycles, then go to DONE.
REQ-023 DONE: lasts exactly one cycle with cnt_clr_o=1, done_o=1, en_o=0; then go to IDLE.
REQ-024 abort_i in RUN or DRAIN: go to DONE next cycle with no further enable; abort has priority over stall_i and over the RUN->DRAIN transition in the same cycle; en_o=0 in the abort cycle.
REQ-025 abort_i in IDLE or DONE: ignored.
REQ-026 start_i while busy_o=1: ignored, not queued.
REQ-027 issued_o SHALL hold its value from DRAIN through DONE, and SHALL be cleared only on the next accepted start.
REQ-028 Issued and drain counters SHALL be CNT_WIDTH and clog2(DRAIN_CYCLES+1) bits respectively, with no wrap-around possible given REQ-020.
REQ-029 ready_o, busy_o, cnt_clr_o and done_o SHALL be pure decodes of the state register, with no combinational path from inputs.

Reset
REQ-030 rst=1 SHALL force state IDLE, issued count 0, drain count 0 and latched len 0 at the next clock edge.
REQ-031 Outputs after reset: ready_o=1, busy_o=0, en_o=0, cnt_clr_o=0, done_o=0, issued_o=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no done_o pulse; the counter is cleared by its own reset.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the CNT_WIDTH/DRAIN_CYCLES defaults.
REQ-034 Single module, no sub-modules; a top-level pairs it with the existing address counter instance.

Verification
REQ-035 len=5, stall_i=0: en_o high for exactly 5 consecutive cycles, 2 DRAIN cycles, then one cycle with done_o=cnt_clr_o=1; issued_o=5.
REQ-036 len=4, stall_i high for 3 cycles after the 2nd enable: 4 enables total, en_o=0 during the stall, done_o 3 cycles later than in the unstalled case.
REQ-037 len=0: DONE the cycle after start, zero enables, done_o pulse, then ready_o=1.
REQ-038 len=10, abort_i at the 4th enable cycle: en_o=0 in that cycle, issued_o=3, DONE next cycle, no DRAIN.
REQ-039 start_i pulsed during RUN with len_i=7: ignored, original len=5 burst completes unchanged.
REQ-040 rst asserted in DRAIN: IDLE next cycle, no done_o pulse, issued_o=0, ready_o=1.

Source files
------------

// File: rtl/addr_seq_ctrl_pkg.sv
// Shared types and defaults for the address sequencing controller.
// Holds the FSM state encoding and the default counter and drain sizes.
package addr_seq_ctrl_pkg;

  localparam int unsigned CntWidthDefault    = 7;
  localparam int unsigned DrainCyclesDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/addr_seq_ctrl.sv
// Burst controller that issues len_i increment strobes to an address counter,
// waits for the delayed address pipeline to drain, then clears the counter.
module addr_seq_ctrl
  import addr_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = CntWidthDefault,
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 stall_i,
  input  logic                 abort_i,
  output logic                 en_o,
  output logic                 cnt_clr_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] issued_o
);

  // Keep at least one bit so a zero-cycle drain still elaborates.
  localparam int unsigned DrainW =
      (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [DrainW-1:0]    drain_q, drain_d;
  logic                 en_run;
  logic                 last_en;

  // Abort wins over both the enable and the RUN->DRAIN transition.
  assign en_run  = (state_q == StRun) && !stall_i && !abort_i;
  assign last_en = (issued_q == (len_q - CNT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    drain_d  = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          issued_d = '0;
          if (len_i == '0) begin
            state_d = StDone;
          end else begin
            len_d   = len_i;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StDone;
        end else if (en_run) begin
          issued_d = issued_q + CNT_WIDTH'(1);
          if (last_en) begin
            drain_d = '0;
            state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
          end
        end
      end
      StDrain: begin
        if (abort_i || (drain_q == DrainLast)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ready_o   = (state_q == StIdle);
    busy_o    = (state_q != StIdle);
    cnt_clr_o = (state_q == StDone);
    done_o    = (state_q == StDone);
    en_o      = en_run;
    issued_o  = issued_q;
  end

endmodule
